mont_redc16: RTL and testbench
==============================

# mont_redc16

Bit-serial Montgomery reduction (REDC) engine: consumes the 2W-bit product emitted by the registered Karatsuba multiplier and returns t·2^-W mod n, fully reduced. It sits downstream of the multiplier in the modified Montgomery datapath, closing the multiply→reduce loop. One reduction runs at a time, with valid/ready handshakes on both sides.

## Interface
- W, default 16: operand width; R = 2^W.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset; one clock, sampled on the rising edge of clk.
- in_valid  in  1  t/n are valid.
- in_ready  out  1  engine idle and able to accept; equals (state==IDLE).
- t  in  2W  product to reduce.
- n  in  W  modulus; must be odd, and t < n·R must hold.
- out_valid  out  1  result/err valid; held until accepted.
- out_ready  in  1  downstream accepts.
- result  out  W  t·R^-1 mod n, in range [0, n-1].
- err  out  1  precondition violated (n even, or t ≥ n·R).

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch n and acc=t (acc is 2W+1 bits), clear cnt, and latch err_q = (n[0]==0) | (t ≥ {n, W'b0}). Go to RUN.
- RUN: each cycle, acc = acc[0] ? (acc+n)>>1 : acc>>1, using a 2W+1-bit sum with no truncation before the shift. cnt increments 0..W-1. When cnt==W-1, go to FIX.
- FIX: if acc ≥ n then result=acc-n, else result=acc[W-1:0]. If err_q, force result=0 and err=1. Go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE. result and err hold stable until the transfer.
- An error does not short-circuit the sequence: latency stays fixed and the computed value is discarded.
- in_valid while busy is ignored; the source must hold it until in_ready.
- Width rule: with t < n·R, acc < 2n after RUN, so one conditional subtract suffices.

## Timing
- Reset (rst_n low at an edge): state=IDLE, out_valid=0, result=0, err=0, cnt=0, acc=0. in_ready reads 1 in the cycle after the reset edge.
- Reset mid-RUN, mid-FIX, or in DONE aborts the operation. No output is produced for the aborted input.
- Acceptance edge E0 → RUN for edges E1..EW → FIX at edge EW+1 → out_valid=1 in the cycle after EW+1. Latency is W+1 cycles from acceptance to out_valid (17 for W=16).
- Output transfer edge → IDLE; in_ready=1 the next cycle. There is no same-cycle accept-on-drain. Minimum issue interval is W+3 cycles with out_ready tied high.
- out_valid deasserts on the transfer edge. result and err keep their last values until the next FIX.
- in_ready=0 in RUN, FIX and DONE.

## Structure
- Package mont_pkg holds:
  - default W=16;
  - the state enum {IDLE, RUN, FIX, DONE};
  - a CNT_W = $clog2(W) constant.
- Optional sub-module mont_redc_step: a purely combinational single iteration (acc, n → next acc). Reuse it for future radix-4 variants.
- Everything else stays in one module: FSM, counter, acc/n registers, final subtract and err compare.

## Test plan
- n=0xFFF1, t=0x0000484E (15·1234) → result=0x04D2 (1234), err=0, out_valid 17 cycles after acceptance.
- n=0xFFF1, t=0x000000E1 (225) → result=0x000F. Then t=0x0000FFF1 (t=n) → result=0x0000, which exercises the FIX subtract.
- n=0xFFF1, t=0xFFF0FFFF (n·R-1) → err=0, result<n matching a reference model. Then t=0xFFF10000 → err=1, result=0.
- n=0x1000 (even), t=0x00001234 → err=1, result=0, same 17-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result, err and out_valid stable, in_ready=0, and an in_valid pulse is ignored. Raise out_ready → in_ready=1 on the following cycle.
- Reset: drop rst_n for one edge at RUN cnt=5 → out_valid=0, result=0, in_ready=1 next cycle. A fresh t=0x000000E1 with n=0xFFF1 then yields 0x000F.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared constants and state encoding for the Montgomery REDC engine.
package mont_pkg;

  localparam int unsigned DEF_W = 16;
  localparam int unsigned CNT_W = $clog2(DEF_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mont_redc_step.sv
// One radix-2 REDC iteration: halve acc, first adding n when acc is odd.
module mont_redc_step
  import mont_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic [2*W:0]   acc_i,
  input  logic [W-1:0]   n_i,
  output logic [2*W:0]   acc_c_o
);

  localparam int unsigned AW = 2 * W + 1;

  // One extra bit so the carry of acc+n survives until after the shift.
  logic [AW:0] sum_c;

  always_comb begin
    sum_c   = (AW + 1)'(acc_i) + (AW + 1)'(n_i);
    acc_c_o = acc_i[0] ? AW'(sum_c >> 1) : (acc_i >> 1);
  end

endmodule

// File: rtl/mont_redc16.sv
// Bit-serial Montgomery reduction: result = t * 2^-W mod n, fully reduced,
// with valid/ready handshakes on input and output.
module mont_redc16
  import mont_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   t,
  input  logic [W-1:0]     n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic             err
);

  localparam int unsigned AW = 2 * W + 1;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d, acc_step_c;
  logic [W-1:0]    n_q, n_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bad_q, bad_d;
  logic [W-1:0]    res_q, res_d;
  logic            err_q, err_d;
  logic            vld_q, vld_d;

  mont_redc_step #(.W(W)) u_step (
    .acc_i   (acc_q),
    .n_i     (n_q),
    .acc_c_o (acc_step_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    res_d   = res_q;
    err_d   = err_q;
    vld_d   = vld_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          n_d     = n;
          acc_d   = AW'(t);
          cnt_d   = '0;
          bad_d   = ~n[0] | (t >= {n, {W{1'b0}}});
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_step_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // A bad precondition still runs the full sequence; its value is dropped here.
        if (bad_q) begin
          res_d = '0;
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
          res_d = (acc_q >= AW'(n_q)) ? W'(acc_q - AW'(n_q)) : acc_q[W-1:0];
        end
        vld_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      res_q   <= res_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = vld_q;
  assign result    = res_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mont_redc16.sv
// Directed and randomized checks of mont_redc16 against an arithmetic REDC model.
module tb_mont_redc16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] t;
  logic [15:0] n;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        err;

  int ncmp;
  int nfail;

  mont_redc16 #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .t         (t),
    .n         (n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference: the unique r in [0,n) with r*2^16 == t (mod n), found by search.
  function automatic logic [16:0] ref_redc(input longint tv, input longint nv);
    longint rm;
    longint tm;
    if ((nv % 2) == 0 || tv >= nv * 65536) return {1'b1, 16'h0000};
    rm = 65536 % nv;
    tm = tv % nv;
    for (longint r = 0; r < nv; r++) begin
      if (((r * rm) % nv) == tm) return {1'b0, 16'(r)};
    end
    return {1'b1, 16'hDEAD};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand pair, then wait (bounded) for out_valid and check latency.
  task automatic issue(input logic [31:0] tv, input logic [15:0] nv, input string tag);
    int k;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    t        = tv;
    n        = nv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 5) chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    end
    chk({tag, "_latency"}, 64'(k), 64'd17);
  endtask

  task automatic run_op(input logic [31:0] tv, input logic [15:0] nv, input string tag);
    logic [16:0] exp;
    exp = ref_redc(longint'(tv), longint'(nv));
    issue(tv, nv, tag);
    chk({tag, "_result"}, 64'(result), 64'(exp[15:0]));
    chk({tag, "_err"}, 64'(err), 64'(exp[16]));
    chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drain"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    logic [15:0] r0;
    logic        e0;
    logic [15:0] nv;
    logic [31:0] tv;
    longint      lim;
    int          seen;

    ncmp      = 0;
    nfail     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    t         = '0;
    n         = '0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_state", {45'd0, in_ready, out_valid, err, result}, {45'd0, 1'b1, 1'b0, 1'b0, 16'h0000});

    // Directed vectors from the known-answer set.
    run_op(32'h0000484E, 16'hFFF1, "kat1234");
    chk("kat1234_const", 64'(result), 64'h04D2);
    drain("kat1234");
    run_op(32'h000000E1, 16'hFFF1, "kat225");
    chk("kat225_const", 64'(result), 64'h000F);
    drain("kat225");
    run_op(32'h0000FFF1, 16'hFFF1, "t_eq_n");
    chk("t_eq_n_const", 64'(result), 64'h0000);
    drain("t_eq_n");
    run_op(32'hFFF0FFFF, 16'hFFF1, "t_max");
    drain("t_max");
    run_op(32'hFFF10000, 16'hFFF1, "t_over");
    chk("t_over_const", {47'd0, err, result}, {47'd0, 1'b1, 16'h0000});
    drain("t_over");
    run_op(32'h00001234, 16'h1000, "n_even");
    chk("n_even_const", {47'd0, err, result}, {47'd0, 1'b1, 16'h0000});
    drain("n_even");

    // Randomized operands, mostly legal, with some even moduli and oversize products.
    for (int i = 0; i < 16; i++) begin
      nv = 16'($urandom) | 16'h0001;
      if (i % 5 == 4) nv = nv & 16'hFFFE;
      lim = longint'(nv) * 65536;
      tv  = 32'(longint'($urandom) % ((lim == 0) ? 64'd1 : lim));
      if (i % 7 == 6 && lim < 64'h1_0000_0000) begin
        tv = 32'(lim + (longint'($urandom) % (64'h1_0000_0000 - lim)));
      end
      run_op(tv, nv, $sformatf("rnd%0d", i));
      drain($sformatf("rnd%0d", i));
    end

    // Backpressure: outputs must hold in DONE and an in_valid pulse must be ignored.
    run_op(32'h0012_3456, 16'hC35B, "bp");
    r0 = result;
    e0 = err;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c == 3);
      t        = 32'h0000_00E1;
      n        = 16'hFFF1;
      chk($sformatf("bp_hold%0d", c), {45'd0, out_valid, in_ready, e0 ^ err, result},
          {45'd0, 1'b1, 1'b0, 1'b0, r0});
    end
    in_valid = 1'b0;
    drain("bp");
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready || result !== r0) seen++;
    end
    chk("bp_no_spurious_op", 64'(seen), 64'd0);

    // Reset in the middle of RUN aborts the reduction without producing output.
    @(negedge clk);
    t        = 32'h0000_484E;
    n        = 16'hFFF1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_run", {45'd0, in_ready, out_valid, err, result}, {45'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_output", 64'(seen), 64'd0);
    run_op(32'h000000E1, 16'hFFF1, "post_rst");
    chk("post_rst_const", 64'(result), 64'h000F);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
